shared_mem_arbiter: RTL and testbench
=====================================

# shared_mem_arbiter

Round-robin arbiter that shares one single-port synchronous data RAM among `NCORES` processor cores in the multicore build. Each core's MEM stage raises a request and stalls until the arbiter returns a one-cycle acknowledge. The arbiter serialises the accesses, drives the shared RAM port from registers, returns read data, and counts contention cycles for performance tuning.

## Interface

**Parameters**

- `NCORES`, default 4: number of requesting cores, legal range 2..8.
- `AW`, default 14: word-address width of the shared RAM.
- `IW`, default 3: grant-index width; must be at least clog2(`NCORES`).

**Ports** (clock and reset first)

- `Clk`  in  1: the single clock; all state changes on the rising edge.
- `Reset`  in  1: synchronous, active-high reset.
- `req`  in  NCORES: per-core access request; the core holds it high until it sees `ack`.
- `we`  in  NCORES: per-core write enable, qualified by `req`.
- `addr`  in  NCORES*AW: per-core word address; core i uses bits [i*AW +: AW].
- `wdata`  in  NCORES*32: per-core write data; core i uses bits [i*32 +: 32].
- `ack`  out  NCORES: one-hot, one-cycle pulse; the access for core i is complete.
- `rdata`  out  32: read data; equals `mem_rdata` while `ack` is nonzero, else 0.
- `mem_en`  out  1: RAM enable (registered).
- `mem_we`  out  1: RAM write enable (registered).
- `mem_addr`  out  AW: RAM address (registered).
- `mem_wdata`  out  32: RAM write data (registered).
- `mem_rdata`  in  32: RAM read data, valid the cycle after the RAM samples `mem_en`.
- `grant_idx`  out  IW: index of the core currently being served; holds its last value in IDLE.
- `busy`  out  1: high when the state is not IDLE.
- `contention`  out  32: count of IDLE cycles in which two or more `req` bits are high.

## Operation

**States:** IDLE, ACCESS, RESP.

- **IDLE**
  - If `req` is 0, stay in IDLE.
  - Otherwise pick the winner g: the first set `req` bit scanning upward from (`last`+1) mod NCORES and wrapping.
  - On that edge register `last`=g, `grant_idx`=g, `mem_en`=1, `mem_we`=`we`[g], `mem_addr`=`addr`[g], `mem_wdata`=`wdata`[g], and go to ACCESS.
- **ACCESS**
  - The RAM samples the port at the end of this cycle.
  - On that edge clear `mem_en` and `mem_we`, set `ack`[g]=1, and go to RESP.
  - `mem_addr` and `mem_wdata` hold their values.
- **RESP**
  - `ack`[g] is high and `rdata`=`mem_rdata`. For writes `rdata` is don't-care and the core ignores it.
  - On that edge clear `ack` and go to IDLE.
  - The winner's `req` during RESP is ignored. A `req` still high in the following IDLE cycle is treated as a new request.
- **Round-robin pointer:** `last` resets to NCORES-1, so core 0 wins first after reset. A core that was just served has the lowest priority at the next arbitration.
- **Request sampling:** `req`, `we`, `addr` and `wdata` are sampled only in IDLE. Changes while the block is busy have no effect on the current access.
- **`contention` counter:** increments in IDLE when popcount(`req`) ≥ 2. It wraps modulo 2^32.
- **Unused bits:** bits of `req` at index ≥ NCORES do not exist. `grant_idx` upper bits are 0.

## Timing

- **Latency:** `req` seen in IDLE at cycle t gives `mem_en`=1 in cycle t+1 and `ack` plus valid `rdata` in cycle t+2.
- **Throughput:** at most one access per 3 cycles. With N cores requesting continuously, each core is served once every 3N cycles.
- **Reset values:**
  - State IDLE, `last`=NCORES-1.
  - `ack`, `mem_en`, `mem_we`, `mem_addr`, `mem_wdata`, `grant_idx`, `contention` all 0.
  - `busy`=0 and `rdata`=0.
- **Reset mid-operation:** everything above returns to its reset value on the reset edge and no `ack` is issued.
  - If reset is high during ACCESS, the RAM still samples `mem_en`/`mem_we` on that edge, so a write commits. The core's pipeline is reset at the same time.
- **Simultaneous events:**
  - Reset has priority over every state update.
  - A new `req` arriving in RESP is not lost; it is arbitrated in the next IDLE cycle.
- **No combinational path** from `req` to `ack` or to any `mem_*` output. `rdata` is the only combinational output.

## Test plan

- **Single read:** after reset, `req`=0001, `we`=0, `addr0`=0x0010, RAM[0x10]=0xDEADBEEF → `mem_en`=1 with `mem_addr`=0x10 at t+1; `ack`=0001 with `rdata`=0xDEADBEEF at t+2; `busy` low at t+3.
- **Write then read:** core 2 writes 0x12345678 to 0x0020, then core 1 reads 0x0020 → the write `ack` is 0100; the read `ack` is 0010 with `rdata`=0x12345678.
- **Round robin:** `req`=1111 held, each core dropping `req` for one cycle after its `ack` → `ack` sequence 0001, 0010, 0100, 1000, 0001; `contention` increments on each arbitration cycle.
- **Wrap and priority:** serve core 3, then assert `req`=1001 → core 0 wins. Serve core 0, then assert `req`=1001 → core 3 wins.
- **Reset during ACCESS:** core 0 write to 0x0030 of 0xAAAA5555 with `Reset` high in the ACCESS cycle → no `ack`; all outputs 0 next cycle; RAM[0x30]=0xAAAA5555; the next grant goes to core 0.
- **Idle stability:** `req`=0 for 100 cycles → `mem_en` stays 0, `ack` stays 0, `contention` stays 0.

Source files
------------

// File: rtl/shared_mem_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM among NCORES cores.
// Each access takes IDLE -> ACCESS -> RESP; RAM port outputs are registered.
module shared_mem_arbiter #(
    parameter int NCORES = 4,
    parameter int AW     = 14,
    parameter int IW     = 3
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic [NCORES-1:0]      req,
    input  logic [NCORES-1:0]      we,
    input  logic [NCORES*AW-1:0]   addr,
    input  logic [NCORES*32-1:0]   wdata,
    output logic [NCORES-1:0]      ack,
    output logic [31:0]            rdata,
    output logic                   mem_en,
    output logic                   mem_we,
    output logic [AW-1:0]          mem_addr,
    output logic [31:0]            mem_wdata,
    input  logic [31:0]            mem_rdata,
    output logic [IW-1:0]          grant_idx,
    output logic                   busy,
    output logic [31:0]            contention
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    localparam int unsigned NC = NCORES;

    logic [1:0]        state;
    logic [IW-1:0]     last;

    logic              found;
    logic [IW-1:0]     win_idx;
    logic              win_we;
    logic [AW-1:0]     win_addr;
    logic [31:0]       win_wdata;
    logic [NCORES-1:0] grant_onehot;
    int unsigned       nreq;

    // Scan from last+1 upward with wrap; the inner loop keeps all indices constant.
    always_comb begin
        found     = 1'b0;
        win_idx   = '0;
        win_we    = 1'b0;
        win_addr  = '0;
        win_wdata = '0;
        for (int unsigned k = 1; k <= NC; k++) begin
            for (int unsigned i = 0; i < NC; i++) begin
                if (!found && req[i] && (i == ((32'(last) + k) % NC))) begin
                    found     = 1'b1;
                    win_idx   = IW'(i);
                    win_we    = we[i];
                    win_addr  = addr[i*AW +: AW];
                    win_wdata = wdata[i*32 +: 32];
                end
            end
        end
    end

    always_comb begin
        nreq         = 0;
        grant_onehot = '0;
        for (int unsigned i = 0; i < NC; i++) begin
            nreq            = nreq + 32'(req[i]);
            grant_onehot[i] = (grant_idx == IW'(i));
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= S_IDLE;
            last       <= IW'(NCORES - 1);
            grant_idx  <= '0;
            ack        <= '0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            contention <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (nreq >= 2) begin
                        contention <= contention + 32'd1;
                    end
                    if (found) begin
                        last      <= win_idx;
                        grant_idx <= win_idx;
                        mem_en    <= 1'b1;
                        mem_we    <= win_we;
                        mem_addr  <= win_addr;
                        mem_wdata <= win_wdata;
                        state     <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                    ack    <= grant_onehot;
                    state  <= S_RESP;
                end
                S_RESP: begin
                    ack   <= '0;
                    state <= S_IDLE;
                end
                default: begin
                    ack   <= '0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy  = (state != S_IDLE);
    assign rdata = (|ack) ? mem_rdata : '0;

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Directed bench for shared_mem_arbiter with a behavioural single-port RAM.
module tb_shared_mem_arbiter;

    logic         Clk = 1'b0;
    logic         Reset;
    logic [3:0]   req;
    logic [3:0]   we;
    logic [55:0]  addr;
    logic [127:0] wdata;
    logic [3:0]   ack;
    logic [31:0]  rdata;
    logic         mem_en;
    logic         mem_we;
    logic [13:0]  mem_addr;
    logic [31:0]  mem_wdata;
    logic [31:0]  mem_rdata;
    logic [2:0]   grant_idx;
    logic         busy;
    logic [31:0]  contention;

    logic         pl_en;
    logic [13:0]  pl_addr;
    logic [31:0]  pl_data;
    logic [31:0]  ram [0:16383];

    int n_assert = 0;
    int n_fail   = 0;

    shared_mem_arbiter #(.NCORES(4), .AW(14), .IW(3)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .req        (req),
        .we         (we),
        .addr       (addr),
        .wdata      (wdata),
        .ack        (ack),
        .rdata      (rdata),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .grant_idx  (grant_idx),
        .busy       (busy),
        .contention (contention)
    );

    always #5 Clk = ~Clk;

    // Read-first synchronous RAM, plus a preload port for the bench.
    always @(posedge Clk) begin
        if (pl_en) ram[pl_addr] <= pl_data;
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            mem_rdata <= ram[mem_addr];
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout, required finish");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        assert (act === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h required %h", tag, act, exp);
        end
    endtask

    task automatic set_core(input int c, input logic w, input logic [13:0] a, input logic [31:0] d);
        we[c]             = w;
        addr[c*14 +: 14]  = a;
        wdata[c*32 +: 32] = d;
    endtask

    // Called in an IDLE cycle with req already applied; returns in the next IDLE cycle.
    task automatic serve(input string tag, input int g, input logic [3:0] exp_ack,
                         input logic exp_we, input logic [13:0] exp_addr, input logic [31:0] exp_wd,
                         input logic chk_rd, input logic [31:0] exp_rd, input logic [31:0] exp_cont);
        tick;
        chk({tag, ".acc.busy"},   64'(busy), 64'(1'b1));
        chk({tag, ".acc.mem_en"}, 64'(mem_en), 64'(1'b1));
        chk({tag, ".acc.mem_we"}, 64'(mem_we), 64'(exp_we));
        chk({tag, ".acc.addr"},   64'(mem_addr), 64'(exp_addr));
        chk({tag, ".acc.wdata"},  64'(mem_wdata), 64'(exp_wd));
        chk({tag, ".acc.grant"},  64'(grant_idx), 64'(g));
        chk({tag, ".acc.ack"},    64'(ack), 64'(4'b0000));
        chk({tag, ".acc.cont"},   64'(contention), 64'(exp_cont));
        tick;
        chk({tag, ".resp.ack"},    64'(ack), 64'(exp_ack));
        chk({tag, ".resp.mem_en"}, 64'(mem_en), 64'(1'b0));
        chk({tag, ".resp.mem_we"}, 64'(mem_we), 64'(1'b0));
        chk({tag, ".resp.addr"},   64'(mem_addr), 64'(exp_addr));
        if (chk_rd) chk({tag, ".resp.rdata"}, 64'(rdata), 64'(exp_rd));
        tick;
        chk({tag, ".idle.busy"},  64'(busy), 64'(1'b0));
        chk({tag, ".idle.ack"},   64'(ack), 64'(4'b0000));
        chk({tag, ".idle.rdata"}, 64'(rdata), 64'(32'h0));
        chk({tag, ".idle.grant"}, 64'(grant_idx), 64'(g));
    endtask

    initial begin
        Reset = 1'b1; req = '0; we = '0; addr = '0; wdata = '0;
        pl_en = 1'b1; pl_addr = 14'h0010; pl_data = 32'hDEADBEEF;
        tick;
        pl_en = 1'b0;
        tick;
        chk("rst.ack",    64'(ack), 64'(4'b0000));
        chk("rst.mem_en", 64'(mem_en), 64'(1'b0));
        chk("rst.mem_we", 64'(mem_we), 64'(1'b0));
        chk("rst.addr",   64'(mem_addr), 64'(14'h0));
        chk("rst.wdata",  64'(mem_wdata), 64'(32'h0));
        chk("rst.grant",  64'(grant_idx), 64'(3'd0));
        chk("rst.busy",   64'(busy), 64'(1'b0));
        chk("rst.rdata",  64'(rdata), 64'(32'h0));
        chk("rst.cont",   64'(contention), 64'(32'h0));
        Reset = 1'b0;

        // Single read by core 0
        set_core(0, 1'b0, 14'h0010, 32'h0);
        req = 4'b0001;
        serve("rd0", 0, 4'b0001, 1'b0, 14'h0010, 32'h0, 1'b1, 32'hDEADBEEF, 32'd0);

        // Core 2 writes, core 1 reads it back
        set_core(2, 1'b1, 14'h0020, 32'h12345678);
        req = 4'b0100;
        serve("wr2", 2, 4'b0100, 1'b1, 14'h0020, 32'h12345678, 1'b0, 32'h0, 32'd0);
        set_core(1, 1'b0, 14'h0020, 32'h0);
        req = 4'b0010;
        serve("rd1", 1, 4'b0010, 1'b0, 14'h0020, 32'h0, 1'b1, 32'h12345678, 32'd0);
        req = 4'b0000;
        Reset = 1'b1;
        tick;
        Reset = 1'b0;

        // Round robin with all cores requesting; winner drops for one IDLE cycle
        set_core(0, 1'b0, 14'h0040, 32'h0);
        set_core(1, 1'b0, 14'h0041, 32'h0);
        set_core(2, 1'b0, 14'h0042, 32'h0);
        set_core(3, 1'b0, 14'h0043, 32'h0);
        req = 4'b1111;
        serve("rr0", 0, 4'b0001, 1'b0, 14'h0040, 32'h0, 1'b0, 32'h0, 32'd1);
        req = 4'b1110;
        serve("rr1", 1, 4'b0010, 1'b0, 14'h0041, 32'h0, 1'b0, 32'h0, 32'd2);
        req = 4'b1101;
        serve("rr2", 2, 4'b0100, 1'b0, 14'h0042, 32'h0, 1'b0, 32'h0, 32'd3);
        req = 4'b1011;
        serve("rr3", 3, 4'b1000, 1'b0, 14'h0043, 32'h0, 1'b0, 32'h0, 32'd4);
        req = 4'b0111;
        serve("rr4", 0, 4'b0001, 1'b0, 14'h0040, 32'h0, 1'b0, 32'h0, 32'd5);

        // Wrap and priority
        req = 4'b1000;
        serve("wrap3", 3, 4'b1000, 1'b0, 14'h0043, 32'h0, 1'b0, 32'h0, 32'd5);
        req = 4'b1001;
        serve("wrap0", 0, 4'b0001, 1'b0, 14'h0040, 32'h0, 1'b0, 32'h0, 32'd6);
        req = 4'b1001;
        serve("prio3", 3, 4'b1000, 1'b0, 14'h0043, 32'h0, 1'b0, 32'h0, 32'd7);

        // Reset asserted during ACCESS of a write
        set_core(0, 1'b1, 14'h0030, 32'hAAAA5555);
        req = 4'b0001;
        tick;
        chk("rsta.mem_en", 64'(mem_en), 64'(1'b1));
        chk("rsta.mem_we", 64'(mem_we), 64'(1'b1));
        chk("rsta.addr",   64'(mem_addr), 64'(14'h0030));
        Reset = 1'b1;
        req = 4'b0000;
        tick;
        chk("rsta.ack",    64'(ack), 64'(4'b0000));
        chk("rsta.en",     64'(mem_en), 64'(1'b0));
        chk("rsta.we",     64'(mem_we), 64'(1'b0));
        chk("rsta.maddr",  64'(mem_addr), 64'(14'h0));
        chk("rsta.wdata",  64'(mem_wdata), 64'(32'h0));
        chk("rsta.grant",  64'(grant_idx), 64'(3'd0));
        chk("rsta.busy",   64'(busy), 64'(1'b0));
        chk("rsta.rdata",  64'(rdata), 64'(32'h0));
        chk("rsta.cont",   64'(contention), 64'(32'h0));
        Reset = 1'b0;
        set_core(0, 1'b0, 14'h0030, 32'h0);
        set_core(3, 1'b0, 14'h0050, 32'h0);
        req = 4'b1001;
        serve("rstrd", 0, 4'b0001, 1'b0, 14'h0030, 32'h0, 1'b1, 32'hAAAA5555, 32'd1);

        // Idle stability
        req = 4'b0000;
        Reset = 1'b1;
        tick;
        Reset = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick;
            chk("idle.mem_en", 64'(mem_en), 64'(1'b0));
            chk("idle.ack",    64'(ack), 64'(4'b0000));
        end
        chk("idle.cont", 64'(contention), 64'(32'h0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
